// File: rtl/serial_full_subtractor.sv
// Bit-serial W-bit subtractor (diff = a - b, LSB first, one bit per clock).
// Define SERIAL_SUB_OVF_EN to add the registered signed-overflow output ovf.
module full_sub_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

module serial_full_subtractor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  sa, sb, work_nxt;
    logic [CW-1:0] cnt;
    logic          br, d, br_nxt;
    logic          accept, run_step, last_step;

    full_sub_cell u_cell (
        .x   (sa[0]),
        .y   (sb[0]),
        .bin (br),
        .d   (d),
        .bout(br_nxt)
    );

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign accept    = start && (state == IDLE || state == DONE);
    assign run_step  = (state == RUN);
    assign last_step = run_step && (cnt == LAST);

    // Partial result: new bit enters at the MSB, so after W steps bit 0 is the LSB.
    generate
        if (W == 1) begin : g_w1
            assign work_nxt = d;
        end else begin : g_wn
            logic [W-2:0] work;
            assign work_nxt = {d, work};
            always_ff @(posedge clk) begin
                if (rst || accept) work <= '0;
                else if (run_step) work <= work_nxt[W-1:1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sa         <= '0;
            sb         <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (accept) begin
            state <= RUN;
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
        end else if (run_step) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= br_nxt;
            cnt <= cnt + CW'(1);
            if (last_step) begin
                diff       <= work_nxt;
                borrow_out <= br_nxt;
                state      <= DONE;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end else begin
            state <= IDLE;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    // Operand sign bits are consumed by the shifters, so keep copies for the overflow test.
    logic a_msb, b_msb;
    always_ff @(posedge clk) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= a[W-1];
            b_msb <= b[W-1];
        end else if (last_step) begin
            ovf <= (a_msb ^ b_msb) & (d ^ a_msb);
        end
    end
`endif
endmodule

// File: tb/tb_serial_full_subtractor.sv
// Directed bench for serial_full_subtractor (W=8 main instance, W=1 corner instance).
module tb_serial_full_subtractor;
    logic       clk = 1'b0;
    logic       rst, start, start1;
    logic [7:0] a, b, diff;
    logic [0:0] a1, b1, diff1;
    logic       busy, done, borrow_out;
    logic       busy1, done1, borrow1;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf, ovf1;
`endif
    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    serial_full_subtractor #(.W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_full_subtractor #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(borrow1)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

    // Advance one cycle; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        a = 8'h00; b = 8'h00; a1 = 1'b0; b1 = 1'b0;
        step(); step();
        nvec++;
        if ({busy, done, diff, borrow_out} !== 11'd0) begin
            nerr++;
            $display("FAIL reset: busy=%b done=%b diff=%h borrow=%b, want all 0",
                     busy, done, diff, borrow_out);
        end
`ifdef SERIAL_SUB_OVF_EN
        nvec++;
        if (ovf !== 1'b0) begin nerr++; $display("FAIL reset_ovf: got %b want 0", ovf); end
`endif
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        a = 8'd100; b = 8'd37; start = 1'b1;
        step();
        start = 1'b0; a = 8'hAA; b = 8'h55;
        for (int i = 1; i <= 8; i++) begin
            nvec++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                nerr++;
                $display("FAIL basic_latency cyc %0d: busy=%b done=%b want busy=1 done=0", i, busy, done);
            end
            step();
        end
        nvec++;
        if (done !== 1'b1 || busy !== 1'b0 || diff !== 8'd63 || borrow_out !== 1'b0) begin
            nerr++;
            $display("FAIL basic_result: done=%b busy=%b diff=%0d borrow=%b want 1 0 63 0",
                     done, busy, diff, borrow_out);
        end
        step();
        nvec++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== 8'd63) begin
            nerr++;
            $display("FAIL basic_hold: done=%b busy=%b diff=%0d want 0 0 63", done, busy, diff);
        end
    endtask

    task automatic test_borrow();
        a = 8'd5; b = 8'd9; start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        nvec++;
        if (done !== 1'b1 || diff !== 8'hFC || borrow_out !== 1'b1) begin
            nerr++;
            $display("FAIL borrow_5_9: done=%b diff=%h borrow=%b want 1 fc 1", done, diff, borrow_out);
        end
        step();
        a = 8'd0; b = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        nvec++;
        if (done !== 1'b1 || diff !== 8'h00 || borrow_out !== 1'b0) begin
            nerr++;
            $display("FAIL zero_zero: done=%b diff=%h borrow=%b want 1 00 0", done, diff, borrow_out);
        end
        step();
    endtask

    task automatic test_back_to_back();
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;
        repeat (8) step();
        nvec++;
        if (done !== 1'b1 || diff !== 8'h00 || borrow_out !== 1'b0) begin
            nerr++;
            $display("FAIL b2b_first: done=%b diff=%h borrow=%b want 1 00 0", done, diff, borrow_out);
        end
        a = 8'd1; b = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        nvec++;
        if (busy !== 1'b1 || done !== 1'b0 || diff !== 8'h00) begin
            nerr++;
            $display("FAIL b2b_restart: busy=%b done=%b diff=%h want 1 0 00", busy, done, diff);
        end
        repeat (8) step();
        nvec++;
        if (done !== 1'b1 || diff !== 8'hFF || borrow_out !== 1'b1) begin
            nerr++;
            $display("FAIL b2b_second: done=%b diff=%h borrow=%b want 1 ff 1", done, diff, borrow_out);
        end
        step();
    endtask

    task automatic test_ignore_start();
        a = 8'd200; b = 8'd50; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (i == 3) begin start = 1'b1; a = 8'd1; b = 8'd1; end
            else begin start = 1'b0; a = 8'd7; b = 8'd9; end
            nvec++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                nerr++;
                $display("FAIL ignore_busy cyc %0d: busy=%b done=%b want 1 0", i, busy, done);
            end
            step();
        end
        start = 1'b0;
        nvec++;
        if (done !== 1'b1 || diff !== 8'd150 || borrow_out !== 1'b0) begin
            nerr++;
            $display("FAIL ignore_result: done=%b diff=%0d borrow=%b want 1 150 0", done, diff, borrow_out);
        end
        step();
    endtask

    task automatic test_rst_mid_run();
        a = 8'd10; b = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'd0 || borrow_out !== 1'b0) begin
            nerr++;
            $display("FAIL rst_abort: busy=%b done=%b diff=%h borrow=%b want 0 0 00 0",
                     busy, done, diff, borrow_out);
        end
        for (int i = 0; i < 10; i++) begin
            nvec++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                nerr++;
                $display("FAIL rst_no_done cyc %0d: done=%b busy=%b want 0 0", i, done, busy);
            end
            step();
        end
        // Reset wins over a simultaneous start.
        rst = 1'b1; start = 1'b1; a = 8'd9; b = 8'd4;
        step();
        rst = 1'b0; start = 1'b0;
        nvec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            nerr++;
            $display("FAIL rst_priority: busy=%b done=%b want 0 0", busy, done);
        end
        step();
    endtask

    task automatic test_width1();
        a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
        step();
        start1 = 1'b0;
        nvec++;
        if (busy1 !== 1'b1 || done1 !== 1'b0) begin
            nerr++;
            $display("FAIL w1_busy: busy=%b done=%b want 1 0", busy1, done1);
        end
        step();
        nvec++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || diff1 !== 1'b1 || borrow1 !== 1'b1) begin
            nerr++;
            $display("FAIL w1_0m1: done=%b busy=%b diff=%b borrow=%b want 1 0 1 1",
                     done1, busy1, diff1, borrow1);
        end
        a1 = 1'b1; b1 = 1'b0; start1 = 1'b1;
        step();
        start1 = 1'b0;
        step();
        nvec++;
        if (done1 !== 1'b1 || diff1 !== 1'b1 || borrow1 !== 1'b0) begin
            nerr++;
            $display("FAIL w1_1m0: done=%b diff=%b borrow=%b want 1 1 0", done1, diff1, borrow1);
        end
        step();
    endtask

`ifdef SERIAL_SUB_OVF_EN
    task automatic test_ovf();
        logic [7:0] va [3];
        logic [7:0] vb [3];
        logic [7:0] vd [3];
        logic       vbr[3];
        logic       vo [3];
        va = '{8'h7F, 8'h80, 8'h03};
        vb = '{8'hFF, 8'h01, 8'h01};
        vd = '{8'h80, 8'h7F, 8'h02};
        vbr = '{1'b1, 1'b0, 1'b0};
        vo = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            a = va[k]; b = vb[k]; start = 1'b1;
            step();
            start = 1'b0;
            repeat (8) step();
            nvec++;
            if (done !== 1'b1 || diff !== vd[k] || borrow_out !== vbr[k] || ovf !== vo[k]) begin
                nerr++;
                $display("FAIL ovf_%0d: done=%b diff=%h borrow=%b ovf=%b want 1 %h %b %b",
                         k, done, diff, borrow_out, ovf, vd[k], vbr[k], vo[k]);
            end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_ignore_start();
        test_rst_mid_run();
        test_width1();
`ifdef SERIAL_SUB_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
